// File: rtl/photonic_sw_pkg.sv
// Shared types and default sizing for the photonic switch sequencer.
package photonic_sw_pkg;

   localparam int N_SW_DFLT    = 4;
   localparam int N_SLOTS_DFLT = 8;
   localparam int DWELL_W_DFLT = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARM  = 2'd1,
      RUN  = 2'd2
   } state_e;

endpackage

// File: rtl/sw_pattern_table.sv
// Pattern/dwell register file: synchronous write, combinational reads.
module sw_pattern_table
   import photonic_sw_pkg::*;
#(
   parameter int N_SW    = N_SW_DFLT,
   parameter int N_SLOTS = N_SLOTS_DFLT,
   parameter int DWELL_W = DWELL_W_DFLT
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       we,
   input  logic [$clog2(N_SLOTS)-1:0] waddr,
   input  logic [N_SW-1:0]            wpattern,
   input  logic [DWELL_W-1:0]         wdwell,
   input  logic [$clog2(N_SLOTS)-1:0] raddr_a,
   output logic [DWELL_W-1:0]         dwell_a,
   input  logic [$clog2(N_SLOTS)-1:0] raddr_b,
   output logic [N_SW-1:0]            pattern_b
);

   logic [N_SW-1:0]    pat_q [N_SLOTS];
   logic [N_SW-1:0]    pat_d [N_SLOTS];
   logic [DWELL_W-1:0] dwl_q [N_SLOTS];
   logic [DWELL_W-1:0] dwl_d [N_SLOTS];

   always_comb begin
      pat_d = pat_q;
      dwl_d = dwl_q;
      if (we) begin
         pat_d[waddr] = wpattern;
         dwl_d[waddr] = wdwell;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < N_SLOTS; i++) begin
            pat_q[i] <= '0;
            dwl_q[i] <= '0;
         end
      end else begin
         pat_q <= pat_d;
         dwl_q <= dwl_d;
      end
   end

   assign dwell_a   = dwl_q[raddr_a];
   assign pattern_b = pat_q[raddr_b];

endmodule

// File: rtl/photonic_switch_sequencer.sv
// Steps switch drive lines through the pattern table on the 1 MHz tick grid.
//   state | meaning
//   IDLE  | outputs zero, waiting for start
//   ARM   | started, waiting for the next tick to enter slot 0
//   RUN   | holding slot pattern, counting dwell ticks
module photonic_switch_sequencer
   import photonic_sw_pkg::*;
#(
   parameter int N_SW    = N_SW_DFLT,
   parameter int N_SLOTS = N_SLOTS_DFLT,
   parameter int DWELL_W = DWELL_W_DFLT
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       en,
   input  logic                       tick,
   input  logic                       start,
   input  logic                       stop,
   input  logic                       loop,
   input  logic                       cfg_we,
   input  logic [$clog2(N_SLOTS)-1:0] cfg_addr,
   input  logic [N_SW-1:0]            cfg_pattern,
   input  logic [DWELL_W-1:0]         cfg_dwell,
   input  logic [$clog2(N_SLOTS)-1:0] cfg_last,
   output logic [N_SW-1:0]            sw,
   output logic                       busy,
   output logic                       done,
   output logic [$clog2(N_SLOTS)-1:0] slot,
   output logic [DWELL_W-1:0]         dwell_cnt
);

   localparam int AW = $clog2(N_SLOTS);

   state_e             state_q, state_d;
   logic [AW-1:0]      slot_q, slot_d;
   logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
   logic [N_SW-1:0]    sw_q, sw_d;
   logic               loop_q, loop_d;
   logic [AW-1:0]      last_q, last_d;
   logic               done_q, done_d;

   logic [DWELL_W-1:0] cur_dwell;
   logic [AW-1:0]      nxt_addr;
   logic [N_SW-1:0]    nxt_pattern;

   // Next slot to enter: slot+1 while more remain, otherwise wrap/arm to slot 0.
   assign nxt_addr = (state_q == RUN && slot_q < last_q) ? slot_q + AW'(1) : '0;

   sw_pattern_table #(
      .N_SW    (N_SW),
      .N_SLOTS (N_SLOTS),
      .DWELL_W (DWELL_W)
   ) u_table (
      .clk       (clk),
      .reset     (reset),
      .we        (cfg_we),
      .waddr     (cfg_addr),
      .wpattern  (cfg_pattern),
      .wdwell    (cfg_dwell),
      .raddr_a   (slot_q),
      .dwell_a   (cur_dwell),
      .raddr_b   (nxt_addr),
      .pattern_b (nxt_pattern)
   );

   always_comb begin
      state_d     = state_q;
      slot_d      = slot_q;
      dwell_cnt_d = dwell_cnt_q;
      sw_d        = sw_q;
      loop_d      = loop_q;
      last_d      = last_q;
      done_d      = 1'b0;
      if (en) begin
         if (stop) begin
            state_d     = IDLE;
            slot_d      = '0;
            dwell_cnt_d = '0;
            sw_d        = '0;
         end else begin
            case (state_q)
               IDLE: begin
                  if (start) begin
                     state_d = ARM;
                     loop_d  = loop;
                     last_d  = cfg_last;
                  end
               end
               ARM: begin
                  if (tick) begin
                     state_d     = RUN;
                     slot_d      = '0;
                     dwell_cnt_d = '0;
                     sw_d        = nxt_pattern;
                  end
               end
               RUN: begin
                  if (tick) begin
                     // A dwell rewritten below the count falls through to slot end.
                     if (dwell_cnt_q < cur_dwell) begin
                        dwell_cnt_d = dwell_cnt_q + DWELL_W'(1);
                     end else if (slot_q < last_q || loop_q) begin
                        slot_d      = nxt_addr;
                        dwell_cnt_d = '0;
                        sw_d        = nxt_pattern;
                     end else begin
                        state_d     = IDLE;
                        slot_d      = '0;
                        dwell_cnt_d = '0;
                        sw_d        = '0;
                        done_d      = 1'b1;
                     end
                  end
               end
               default: state_d = IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         slot_q      <= '0;
         dwell_cnt_q <= '0;
         sw_q        <= '0;
         loop_q      <= 1'b0;
         last_q      <= '0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         slot_q      <= slot_d;
         dwell_cnt_q <= dwell_cnt_d;
         sw_q        <= sw_d;
         loop_q      <= loop_d;
         last_q      <= last_d;
         done_q      <= done_d;
      end
   end

   assign sw        = sw_q;
   assign busy      = (state_q != IDLE);
   assign done      = done_q & en;
   assign slot      = slot_q;
   assign dwell_cnt = dwell_cnt_q;

endmodule

// File: tb/tb_photonic_switch_sequencer.sv
// Scoreboard bench: each expected output change is queued with its cycle stamp.
module tb_photonic_switch_sequencer;

   localparam int GAP = 200;

   typedef logic [16:0] vec_t;
   typedef struct packed {
      int   cyc;
      vec_t v;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset, en, tick, start, stop, loop, cfg_we;
   logic [2:0] cfg_addr, cfg_last;
   logic [3:0] cfg_pattern;
   logic [7:0] cfg_dwell;
   logic [3:0] sw;
   logic       busy, done;
   logic [2:0] slot;
   logic [7:0] dwell_cnt;

   exp_t  q[$];
   string nq[$];
   int    cyc = 0;
   int    total = 0;
   int    bad = 0;
   bit    mon_on = 1'b0;
   bit    first = 1'b1;
   vec_t  prev_v;
   vec_t  last_exp;

   photonic_switch_sequencer dut (
      .clk         (clk),
      .reset       (reset),
      .en          (en),
      .tick        (tick),
      .start       (start),
      .stop        (stop),
      .loop        (loop),
      .cfg_we      (cfg_we),
      .cfg_addr    (cfg_addr),
      .cfg_pattern (cfg_pattern),
      .cfg_dwell   (cfg_dwell),
      .cfg_last    (cfg_last),
      .sw          (sw),
      .busy        (busy),
      .done        (done),
      .slot        (slot),
      .dwell_cnt   (dwell_cnt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic string fmt(input vec_t v);
      return $sformatf("sw=%b slot=%0d cnt=%0d busy=%b done=%b",
                       v[16:13], v[12:10], v[9:2], v[1], v[0]);
   endfunction

   // Monitor: any change in the observable output vector is a DUT response.
   always @(negedge clk) begin
      vec_t  cur;
      exp_t  e;
      string nm;
      cur = {sw, slot, dwell_cnt, busy, done};
      if (mon_on && (first || cur !== prev_v)) begin
         total++;
         if (q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_change: got %s at cyc %0d, required no change", fmt(cur), cyc);
         end else begin
            e  = q.pop_front();
            nm = nq.pop_front();
            if (cur !== e.v || (e.cyc >= 0 && e.cyc != cyc)) begin
               bad++;
               $display("FAIL %s: got %s at cyc %0d, required %s at cyc %0d",
                        nm, fmt(cur), cyc, fmt(e.v), e.cyc);
            end
         end
         first = 1'b0;
      end
      prev_v = cur;
   end

   task automatic push(input string nm, input int c, input vec_t v);
      exp_t e;
      e.cyc = c;
      e.v   = v;
      q.push_back(e);
      nq.push_back(nm);
      last_exp = v;
   endtask

   // Expected outputs after the coming clock edge; queued only if they change.
   task automatic ex(input string nm, input int s, input int sl, input int c, input int b, input int d);
      vec_t v;
      v = {4'(s), 3'(sl), 8'(c), 1'(b), 1'(d)};
      if (v != last_exp) push(nm, cyc + 1, v);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) step();
   endtask

   task automatic tk(input string nm, input int s, input int sl, input int c, input int b, input int d);
      tick = 1'b1;
      ex(nm, s, sl, c, b, d);
      step();
      tick = 1'b0;
      if (d != 0) ex({nm, "_fall"}, s, sl, c, b, 0);
      idle(GAP);
   endtask

   task automatic wr(input int a, input int p, input int dw);
      cfg_we      = 1'b1;
      cfg_addr    = 3'(a);
      cfg_pattern = 4'(p);
      cfg_dwell   = 8'(dw);
      step();
      cfg_we = 1'b0;
   endtask

   task automatic go(input int l, input int last);
      start    = 1'b1;
      loop     = 1'(l);
      cfg_last = 3'(last);
      ex("start_busy", 0, 0, 0, 1, 0);
      step();
      start = 1'b0;
      idle(3);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish, required finish before time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1; en = 1'b1; tick = 1'b0; start = 1'b0; stop = 1'b0; loop = 1'b0;
      cfg_we = 1'b0; cfg_addr = '0; cfg_last = '0; cfg_pattern = '0; cfg_dwell = '0;
      idle(3);
      reset = 1'b0;
      push("reset_state", -1, '0);
      mon_on = 1'b1;
      idle(3);

      // Single-shot: slot0 = 0001 for 1 tick, slot1 = 0010 for 3 ticks
      wr(0, 4'b0001, 0);
      wr(1, 4'b0010, 2);
      go(0, 1);
      tk("ss_arm",   1, 0, 0, 1, 0);
      tk("ss_s1c0",  2, 1, 0, 1, 0);
      tk("ss_s1c1",  2, 1, 1, 1, 0);
      tk("ss_s1c2",  2, 1, 2, 1, 0);
      tk("ss_done",  0, 0, 0, 0, 1);
      tk("ss_idle",  0, 0, 0, 0, 0);

      // Loop playback, stop together with the 7th tick
      go(1, 1);
      tk("lp_t1", 1, 0, 0, 1, 0);
      tk("lp_t2", 2, 1, 0, 1, 0);
      tk("lp_t3", 2, 1, 1, 1, 0);
      tk("lp_t4", 2, 1, 2, 1, 0);
      tk("lp_t5", 1, 0, 0, 1, 0);
      tk("lp_t6", 2, 1, 0, 1, 0);
      stop = 1'b1; tick = 1'b1;
      ex("lp_stop_tick", 0, 0, 0, 0, 0);
      step();
      stop = 1'b0; tick = 1'b0;
      idle(GAP);
      tk("lp_t8", 0, 0, 0, 0, 0);
      tk("lp_t9", 0, 0, 0, 0, 0);
      tk("lp_t10", 0, 0, 0, 0, 0);

      // Start with tick in IDLE: goes to ARM, tick not consumed
      start = 1'b1; tick = 1'b1; loop = 1'b0; cfg_last = 3'd1;
      ex("pr_start_tick", 0, 0, 0, 1, 0);
      step();
      start = 1'b0; tick = 1'b0;
      idle(GAP);
      tk("pr_first", 1, 0, 0, 1, 0);
      stop = 1'b1;
      ex("pr_stop", 0, 0, 0, 0, 0);
      step();
      stop = 1'b0;
      idle(3);
      stop = 1'b1; start = 1'b1; tick = 1'b1;
      ex("pr_stop_start", 0, 0, 0, 0, 0);
      step();
      stop = 1'b0; start = 1'b0; tick = 1'b0;
      idle(3);
      tk("pr_still_idle", 0, 0, 0, 0, 0);

      // Freeze for 3 ticks mid-slot; done masked when en drops on its cycle
      go(0, 1);
      tk("fz_arm",  1, 0, 0, 1, 0);
      tk("fz_s1c0", 2, 1, 0, 1, 0);
      tk("fz_s1c1", 2, 1, 1, 1, 0);
      en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick = 1'b1;
         step();
         tick = 1'b0;
         idle(GAP);
      end
      stop = 1'b1;
      step();
      stop = 1'b0;
      en = 1'b1;
      idle(3);
      tk("fz_s1c2", 2, 1, 2, 1, 0);
      tick = 1'b1;
      ex("fz_done_masked", 0, 0, 0, 0, 0);
      step();
      tick = 1'b0;
      en = 1'b0;
      step();
      en = 1'b1;
      idle(GAP);

      // Live rewrite of the active slot's dwell, then slot0 pattern
      wr(1, 4'b0010, 5);
      go(1, 1);
      tk("lr_arm",  1, 0, 0, 1, 0);
      tk("lr_s1c0", 2, 1, 0, 1, 0);
      tk("lr_s1c1", 2, 1, 1, 1, 0);
      tk("lr_s1c2", 2, 1, 2, 1, 0);
      tk("lr_s1c3", 2, 1, 3, 1, 0);
      wr(1, 4'b0010, 1);
      tk("lr_cut",  1, 0, 0, 1, 0);
      wr(0, 4'b1000, 0);
      tk("lr_s1b0", 2, 1, 0, 1, 0);
      tk("lr_s1b1", 2, 1, 1, 1, 0);
      tk("lr_wrap_new", 8, 0, 0, 1, 0);
      stop = 1'b1;
      ex("lr_stop", 0, 0, 0, 0, 0);
      step();
      stop = 1'b0;
      idle(3);

      // Reset mid-RUN clears outputs and the table
      go(1, 1);
      tk("rs_arm", 8, 0, 0, 1, 0);
      tk("rs_s1",  2, 1, 0, 1, 0);
      reset = 1'b1;
      ex("rs_reset", 0, 0, 0, 0, 0);
      step();
      reset = 1'b0;
      idle(3);
      go(0, 0);
      tk("rs_arm_cleared", 0, 0, 0, 1, 0);
      tk("rs_done", 0, 0, 0, 0, 1);

      idle(5);
      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL pending_events: got %0d unmatched expectations, required 0 (next %s)",
                  q.size(), nq[0]);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/photonic_switch_sequencer.md
# photonic_switch_sequencer

Scheduler that steps a bank of photonic switch drive lines through a programmable table of switch patterns. Each table slot holds a pattern for a programmed number of 1 MHz ticks. It sits downstream of the 8 MHz / 1 MHz enable generators on the 200 MHz core clock, consuming their one-cycle tick and driving the switch outputs. Supports single-shot and continuous loop playback, abort, and table rewrite during playback.

## Interface
- `N_SW`, 4: number of switch drive lines.
- `N_SLOTS`, 8: table depth, power of two.
- `DWELL_W`, 8: dwell field width, in ticks.
- `clk` in 1: 200 MHz core clock.
- `reset` in 1: synchronous, active-high; clears all state, table and outputs.
- `en` in 1: global enable; low freezes the sequencer state, counters and outputs.
- `tick` in 1: one-cycle strobe from the 1 MHz enable generator.
- `start` in 1: begin playback (level sampled in IDLE only).
- `stop` in 1: abort playback.
- `loop` in 1: sampled with `start`; 1 = wrap to slot 0 after last slot.
- `cfg_we` in 1: table write strobe.
- `cfg_addr` in clog2(N_SLOTS): table slot to write.
- `cfg_pattern` in N_SW: switch pattern for the slot.
- `cfg_dwell` in DWELL_W: hold length; slot lasts `cfg_dwell+1` ticks.
- `cfg_last` in clog2(N_SLOTS): index of the final slot; sampled with `start`.
- `sw` out N_SW: registered switch drive.
- `busy` out 1: high in ARM and RUN.
- `done` out 1: one-cycle pulse at normal single-shot completion.
- `slot` out clog2(N_SLOTS): current slot (debug).
- `dwell_cnt` out DWELL_W: current dwell count (debug).

## Operation
- States: IDLE, ARM, RUN.
- IDLE:
  - `start` moves to ARM and latches `loop` and `cfg_last`.
  - A `tick` in the same cycle as `start` is not consumed.
- ARM:
  - The next `tick` loads slot 0: `sw` = pattern[0], `dwell_cnt` = 0, state moves to RUN.
  - This aligns the sequence to the tick grid.
- RUN, on each `tick`:
  - If `dwell_cnt` < dwell[slot]: increment `dwell_cnt`.
  - Else if `slot` < last: `slot`+1, `dwell_cnt` = 0, `sw` = pattern[slot+1].
  - Else if looping: `slot` = 0, `dwell_cnt` = 0, `sw` = pattern[0].
  - Else: `sw` = 0, `slot` = 0, `dwell_cnt` = 0, pulse `done`, go to IDLE.
- `stop` in any state:
  - Goes to IDLE with `sw` = 0, `slot` = 0, `dwell_cnt` = 0, no `done` pulse.
  - `stop` has priority over `start` and `tick` in the same cycle.
- `en` low:
  - `tick`, `start` and `stop` are ignored; all state and outputs hold.
  - `done` is held low while `en` is low.
  - `reset` and `cfg_we` are still honoured.
- Table writes are accepted in any state.
  - Pattern and dwell are read at slot entry and on each tick comparison.
  - A write to the active slot changes its dwell limit immediately; its pattern takes effect on the next entry.
  - If the rewritten dwell is already below `dwell_cnt`, the slot ends on the next tick (comparison uses ≥).
- `dwell_cnt` never wraps; the maximum dwell is 2^DWELL_W ticks.

## Timing
- Reset values:
  - `sw` = 0, `busy` = 0, `done` = 0, `slot` = 0, `dwell_cnt` = 0.
  - State = IDLE; all table entries = 0.
- `tick` at cycle t changes `sw`, `slot`, `dwell_cnt` and state at t+1 (1-cycle latency).
- `done` is high only in cycle t+1, coincident with `sw` returning to 0 and `busy` falling.
- `busy` rises the cycle after `start` is accepted.
- A `stop` at cycle t clears outputs at t+1.
- `cfg_we` at t is visible to a slot entry at t+1 or later.
- Slot duration is exactly (dwell+1) tick periods, i.e. (dwell+1) µs at 1 MHz.

## Structure
- Package `photonic_sw_pkg`:
  - State enum {IDLE, ARM, RUN}.
  - Default `N_SW`, `N_SLOTS`, `DWELL_W` constants.
- Sub-module `sw_pattern_table`:
  - N_SLOTS × (N_SW + DWELL_W) register file.
  - Synchronous write, combinational read, cleared by `reset`.
- FSM and dwell counter live in the top module.

## Test plan
- Single-shot: table slot0 = {0001, dwell 0}, slot1 = {0010, dwell 2}; `cfg_last` = 1, `loop` = 0; `start`, then ticks every 200 cycles.
  - -> `sw` = 0001 for 1 tick, then 0010 for 3 ticks, then 0 with one `done` pulse; `busy` low afterwards.
- Loop: same table with `loop` = 1, 10 ticks.
  - -> `sw` sequence 0001, 0010, 0010, 0010, 0001, …; no `done`.
  - `stop` at tick 7 -> `sw` = 0 next cycle, no `done`.
- Priority: `start` and `tick` in the same cycle in IDLE -> state ARM, `sw` still 0.
  - `stop` + `tick` in RUN -> IDLE, `sw` = 0.
- Freeze: drop `en` for 3 ticks mid-slot -> `dwell_cnt`, `slot` and `sw` unchanged.
  - Raise `en` -> the sequence resumes, the slot ending 3 ticks late.
- Live rewrite: during slot 1 (dwell 5, `dwell_cnt` = 3), write slot1 dwell = 1 -> the slot ends on the next tick.
  - Writing slot0 pattern 1000 while `loop` = 1 -> 1000 appears on the next wrap.
- Reset mid-RUN: assert `reset` for 1 cycle -> all outputs 0 and the table cleared.
  - A subsequent `start` with `cfg_last` = 0 gives `sw` = 0 for 1 tick, then a `done` pulse.
